// File: rtl/pixel_window_shift_if.sv
// Handshake and data bundle for pixel_window_shift.
// The master drives the pixel stream and the downstream ready; the slave is the window itself.
interface pixel_window_shift_if #(
  parameter int N           = 3,
  parameter int CHANNELS    = 3,
  parameter int PXL_CHANNEL = 8
);
  localparam int CNT_W = $clog2(N + 1);

  logic                                        i_clear;
  logic                                        i_valid;
  logic                                        o_ready;
  logic                                        i_sol;
  logic [CHANNELS-1:0][PXL_CHANNEL-1:0]        i_data;
  logic                                        o_valid;
  logic                                        i_ready;
  logic [N-1:0][CHANNELS-1:0][PXL_CHANNEL-1:0] o_window;
  logic [CHANNELS-1:0][PXL_CHANNEL-1:0]        o_data;
  logic [CNT_W-1:0]                            o_fill_count;

  modport master (
    output i_clear, i_valid, i_sol, i_data, i_ready,
    input  o_ready, o_valid, o_window, o_data, o_fill_count
  );

  modport slave (
    input  i_clear, i_valid, i_sol, i_data, i_ready,
    output o_ready, o_valid, o_window, o_data, o_fill_count
  );
endinterface

// File: rtl/pixel_window_shift.sv
// N-tap multi-channel pixel shift window with valid/ready flow control,
// synchronous flush and selectable start-of-line border handling.
module pixel_window_shift #(
  parameter int N           = 3,
  parameter int CHANNELS    = 3,
  parameter int PXL_CHANNEL = 8,
  parameter int PAD_MODE    = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pixel_window_shift_if.slave  bus
);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N);

  typedef logic [CHANNELS-1:0][PXL_CHANNEL-1:0] pixel_t;
  typedef pixel_t [N-1:0]                       window_t;

  if (N < 2 || CHANNELS < 1 || PAD_MODE < 0 || PAD_MODE > 2) begin : g_bad_param
    $error("pixel_window_shift: illegal parameters N=%0d CHANNELS=%0d PAD_MODE=%0d",
           N, CHANNELS, PAD_MODE);
  end

  window_t          window_q, window_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ready;
  logic             accept;

  // A stalled window (valid and not taken) blocks upstream; otherwise one pixel per clock.
  assign ready  = ~valid_q | bus.i_ready;
  assign accept = bus.i_valid & ready;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    window_d = window_q;
    count_d  = count_q;
    valid_d  = valid_q;

    if (bus.i_clear) begin
      window_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (accept) begin
        if (bus.i_sol) begin
          if (PAD_MODE == 2) begin
            window_d = {N{bus.i_data}};
          end else begin
            window_d    = '0;
            window_d[0] = bus.i_data;
          end
          count_d = (PAD_MODE == 0) ? CNT_W'(1) : FULL;
        end else begin
          for (int k = N - 1; k > 0; k--) begin
            window_d[k] = window_q[k-1];
          end
          window_d[0] = bus.i_data;
          count_d     = (count_q == FULL) ? FULL : count_q + 1'b1;
        end
      end

      if (accept && count_d == FULL) begin
        valid_d = 1'b1;
      end else if (bus.i_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      window_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_valid      = valid_q;
  assign bus.o_window     = window_q;
  assign bus.o_data       = window_q[N-1];
  assign bus.o_fill_count = count_q;
endmodule
